// File: rtl/id_ex_stage_pkg.sv
// Shared CPU definitions for the ID/EX slice: control-bundle layout, ALUOp codes,
// opcodes and the control-scrubbing helper used when the stage captures an instruction.
package id_ex_stage_pkg;

  localparam int CTRL_W = 11;

  // Bit positions inside {RegDst,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,Jump,SignZero,ALUOp[1:0]}
  localparam int CTRL_REG_DST   = 10;
  localparam int CTRL_ALU_SRC   = 9;
  localparam int CTRL_MEM_TO_REG = 8;
  localparam int CTRL_REG_WRITE = 7;
  localparam int CTRL_MEM_READ  = 6;
  localparam int CTRL_MEM_WRITE = 5;
  localparam int CTRL_BRANCH    = 4;
  localparam int CTRL_JUMP      = 3;
  localparam int CTRL_SIGN_ZERO = 2;
  localparam int CTRL_ALU_OP_HI = 1;
  localparam int CTRL_ALU_OP_LO = 0;

  typedef enum logic [1:0] {
    ALU_OP_OR  = 2'b00,
    ALU_OP_SUB = 2'b01,
    ALU_OP_ADD = 2'b10,
    ALU_OP_AND = 2'b11
  } alu_op_e;

  typedef enum logic [5:0] {
    OPC_RTYPE = 6'h00,
    OPC_J     = 6'h02,
    OPC_BEQ   = 6'h04,
    OPC_ADDI  = 6'h08,
    OPC_ORI   = 6'h0D,
    OPC_LW    = 6'h23,
    OPC_SW    = 6'h2B
  } opcode_e;

  // Instructions that never write a register may carry don't-care RegDst/MemtoReg;
  // force them to 0 so EX and forwarding never see X.
  function automatic logic [CTRL_W-1:0] scrubCtrl(input logic [CTRL_W-1:0] ctrl);
    logic [CTRL_W-1:0] result;
    result = ctrl;
    if (!ctrl[CTRL_REG_WRITE]) begin
      result[CTRL_REG_DST]    = 1'b0;
      result[CTRL_MEM_TO_REG] = 1'b0;
    end
    return result;
  endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Combinational load-use hazard detection between the load in EX and the
// instruction currently being decoded.
module hazard_detect
  import id_ex_stage_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  exValid,
  input  logic                  exMemRead,
  input  logic [REG_ADDR_W-1:0] exRt,
  input  logic                  idValid,
  input  logic                  flush,
  input  logic [CTRL_W-1:0]     idCtrl,
  input  logic [REG_ADDR_W-1:0] idRs,
  input  logic [REG_ADDR_W-1:0] idRt,
  output logic                  loadUse,
  output logic                  stall
);

  logic usesRt;

  // rt is a source for R-type ALU ops, stores (store data) and branches (compare).
  assign usesRt = ~idCtrl[CTRL_ALU_SRC] | idCtrl[CTRL_MEM_WRITE] | idCtrl[CTRL_BRANCH];

  // A load targeting r0 produces nothing to wait for.
  assign loadUse = exValid & exMemRead & (exRt != '0) &
                   ((exRt == idRs) | (usesRt & (exRt == idRt)));

  // A flush kills the dependent instruction anyway, so holding upstream would be wasted.
  assign stall = idValid & loadUse & ~flush;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded control, operands, extended immediate and
// register fields, inserts bubbles on flush/load-use and keeps saturating statistics.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int PC_W       = 32,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid_i,
  input  logic                  flush_i,
  input  logic [CTRL_W-1:0]     id_ctrl_i,
  input  logic [DATA_W-1:0]     id_rs_data_i,
  input  logic [DATA_W-1:0]     id_rt_data_i,
  input  logic [15:0]           id_imm_i,
  input  logic [REG_ADDR_W-1:0] id_rs_i,
  input  logic [REG_ADDR_W-1:0] id_rt_i,
  input  logic [REG_ADDR_W-1:0] id_rd_i,
  input  logic [PC_W-1:0]       id_pc4_i,
  output logic                  stall_o,
  output logic                  ex_valid_o,
  output logic [CTRL_W-1:0]     ex_ctrl_o,
  output logic [DATA_W-1:0]     ex_rs_data_o,
  output logic [DATA_W-1:0]     ex_rt_data_o,
  output logic [DATA_W-1:0]     ex_imm_o,
  output logic [REG_ADDR_W-1:0] ex_rs_o,
  output logic [REG_ADDR_W-1:0] ex_rt_o,
  output logic [REG_ADDR_W-1:0] ex_rd_o,
  output logic [PC_W-1:0]       ex_pc4_o,
  output logic [CNT_W-1:0]      bubble_cnt_o,
  output logic [CNT_W-1:0]      flush_cnt_o
);

  logic              loadUse;
  logic              capture;
  logic              countFlush;
  logic [DATA_W-1:0] extImm;

  hazard_detect #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_hazard_detect (
    .exValid  (ex_valid_o),
    .exMemRead(ex_ctrl_o[CTRL_MEM_READ]),
    .exRt     (ex_rt_o),
    .idValid  (id_valid_i),
    .flush    (flush_i),
    .idCtrl   (id_ctrl_i),
    .idRs     (id_rs_i),
    .idRt     (id_rt_i),
    .loadUse  (loadUse),
    .stall    (stall_o)
  );

  // Flush outranks stall, which outranks a normal capture.
  assign capture    = id_valid_i & ~flush_i & ~stall_o;
  assign countFlush = flush_i & id_valid_i;

  assign extImm = id_ctrl_i[CTRL_SIGN_ZERO] ? {{(DATA_W-16){1'b0}}, id_imm_i}
                                            : {{(DATA_W-16){id_imm_i[15]}}, id_imm_i};

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; all pipeline registers are plain flops, so each gets an async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_o   <= 1'b0;
      ex_ctrl_o    <= '0;
      ex_rs_data_o <= '0;
      ex_rt_data_o <= '0;
      ex_imm_o     <= '0;
      ex_rs_o      <= '0;
      ex_rt_o      <= '0;
      ex_rd_o      <= '0;
      ex_pc4_o     <= '0;
    end else if (capture) begin
      ex_valid_o   <= 1'b1;
      ex_ctrl_o    <= scrubCtrl(id_ctrl_i);
      ex_rs_data_o <= id_rs_data_i;
      ex_rt_data_o <= id_rt_data_i;
      ex_imm_o     <= extImm;
      ex_rs_o      <= id_rs_i;
      ex_rt_o      <= id_rt_i;
      ex_rd_o      <= id_rd_i;
      ex_pc4_o     <= id_pc4_i;
    end else begin
      // Bubble: only valid and control matter; datapath fields keep their last value.
      ex_valid_o <= 1'b0;
      ex_ctrl_o  <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt_o <= '0;
      flush_cnt_o  <= '0;
    end else begin
      if (stall_o && (bubble_cnt_o != '1)) bubble_cnt_o <= bubble_cnt_o + CNT_W'(1);
      if (countFlush && (flush_cnt_o != '1)) flush_cnt_o <= flush_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage: pass-through, load-use stalls,
// immediate extension, control scrubbing, reset, flush priority and counter saturation.
module tb_id_ex_stage;

  localparam int CW = 11;

  // Hand-encoded control bundles {RegDst,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,Jump,SignZero,ALUOp}
  localparam logic [CW-1:0] C_ADD     = 11'h482; // RegDst,RegWrite,ALUOp=10
  localparam logic [CW-1:0] C_LW      = 11'h3C2; // ALUSrc,MemtoReg,RegWrite,MemRead,ALUOp=10
  localparam logic [CW-1:0] C_ADDI    = 11'h282; // ALUSrc,RegWrite,ALUOp=10
  localparam logic [CW-1:0] C_ORI     = 11'h286; // ADDI + SignZero
  localparam logic [CW-1:0] C_SW_RAW  = 11'h722; // sw with RegDst/MemtoReg garbage set
  localparam logic [CW-1:0] C_SW_SCRB = 11'h222; // ALUSrc,MemWrite,ALUOp=10

  logic          clk = 1'b0;
  logic          rst_n;
  logic          id_valid_i, flush_i;
  logic [CW-1:0] id_ctrl_i;
  logic [31:0]   id_rs_data_i, id_rt_data_i;
  logic [15:0]   id_imm_i;
  logic [4:0]    id_rs_i, id_rt_i, id_rd_i;
  logic [31:0]   id_pc4_i;
  logic          stall_o, ex_valid_o;
  logic [CW-1:0] ex_ctrl_o;
  logic [31:0]   ex_rs_data_o, ex_rt_data_o, ex_imm_o, ex_pc4_o;
  logic [4:0]    ex_rs_o, ex_rt_o, ex_rd_o;
  logic [15:0]   bubble_cnt_o, flush_cnt_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid_i), .flush_i(flush_i),
    .id_ctrl_i(id_ctrl_i), .id_rs_data_i(id_rs_data_i), .id_rt_data_i(id_rt_data_i),
    .id_imm_i(id_imm_i), .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_rd_i(id_rd_i),
    .id_pc4_i(id_pc4_i), .stall_o(stall_o), .ex_valid_o(ex_valid_o), .ex_ctrl_o(ex_ctrl_o),
    .ex_rs_data_o(ex_rs_data_o), .ex_rt_data_o(ex_rt_data_o), .ex_imm_o(ex_imm_o),
    .ex_rs_o(ex_rs_o), .ex_rt_o(ex_rt_o), .ex_rd_o(ex_rd_o), .ex_pc4_o(ex_pc4_o),
    .bubble_cnt_o(bubble_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [CW-1:0] c, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] rsd,
                       input logic [31:0] rtd, input logic [15:0] imm, input logic [31:0] pc4);
    id_valid_i = v; id_ctrl_i = c; id_rs_i = rs; id_rt_i = rt; id_rd_i = rd;
    id_rs_data_i = rsd; id_rt_data_i = rtd; id_imm_i = imm; id_pc4_i = pc4;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush_i = 1'b0;
    drive(1'b0, '0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 16'd0, 32'd0);
    #3;
    checks++;
    if ({ex_valid_o, ex_ctrl_o, ex_rs_data_o, ex_rt_data_o, ex_imm_o, ex_pc4_o} !== '0) begin
      errors++; $display("FAIL reset_regs got valid=%b ctrl=%h rsd=%h rtd=%h imm=%h pc4=%h want all 0",
                         ex_valid_o, ex_ctrl_o, ex_rs_data_o, ex_rt_data_o, ex_imm_o, ex_pc4_o);
    end
    checks++;
    if ({ex_rs_o, ex_rt_o, ex_rd_o, bubble_cnt_o, flush_cnt_o, stall_o} !== '0) begin
      errors++; $display("FAIL reset_fields got rs=%0d rt=%0d rd=%0d bub=%0d fl=%0d stall=%b want all 0",
                         ex_rs_o, ex_rt_o, ex_rd_o, bubble_cnt_o, flush_cnt_o, stall_o);
    end
    #4 rst_n = 1'b1;
    step();
  endtask

  task automatic test_pass_through();
    drive(1'b1, C_ADD, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 16'h0020, 32'h104);
    step();
    checks++;
    if ({ex_valid_o, ex_ctrl_o, ex_rs_data_o, ex_rt_data_o} !== {1'b1, C_ADD, 32'd5, 32'd7}) begin
      errors++; $display("FAIL pass_data got valid=%b ctrl=%h rsd=%0d rtd=%0d want 1 %h 5 7",
                         ex_valid_o, ex_ctrl_o, ex_rs_data_o, ex_rt_data_o, C_ADD);
    end
    checks++;
    if ({ex_rs_o, ex_rt_o, ex_rd_o, ex_pc4_o} !== {5'd1, 5'd2, 5'd3, 32'h104}) begin
      errors++; $display("FAIL pass_fields got rs=%0d rt=%0d rd=%0d pc4=%h want 1 2 3 00000104",
                         ex_rs_o, ex_rt_o, ex_rd_o, ex_pc4_o);
    end
    // Back-to-back: a second independent instruction captured the very next cycle.
    drive(1'b1, C_ADD, 5'd6, 5'd7, 5'd8, 32'd11, 32'd13, 16'h0000, 32'h108);
    step();
    checks++;
    if ({ex_valid_o, ex_rd_o, ex_rs_data_o, ex_pc4_o} !== {1'b1, 5'd8, 32'd11, 32'h108}) begin
      errors++; $display("FAIL back_to_back got valid=%b rd=%0d rsd=%0d pc4=%h want 1 8 11 00000108",
                         ex_valid_o, ex_rd_o, ex_rs_data_o, ex_pc4_o);
    end
    drive(1'b0, C_ADD, 5'd1, 5'd2, 5'd3, 32'd0, 32'd0, 16'h0, 32'h0);
    step();
    checks++;
    if ({ex_valid_o, ex_ctrl_o} !== '0) begin
      errors++; $display("FAIL idle_bubble got valid=%b ctrl=%h want 0 000", ex_valid_o, ex_ctrl_o);
    end
  endtask

  task automatic test_load_use();
    // lw r2 ; add r4,r2,r1 (rs dependency)
    drive(1'b1, C_LW, 5'd1, 5'd2, 5'd0, 32'd100, 32'd0, 16'h0004, 32'h200);
    step();
    drive(1'b1, C_ADD, 5'd2, 5'd1, 5'd4, 32'd9, 32'd3, 16'h0, 32'h204);
    #1;
    checks++;
    if (stall_o !== 1'b1) begin errors++; $display("FAIL lu_stall got %b want 1", stall_o); end
    step();
    checks++;
    if ({ex_valid_o, ex_ctrl_o, bubble_cnt_o, stall_o} !== {1'b0, 11'h0, 16'd1, 1'b0}) begin
      errors++; $display("FAIL lu_bubble got valid=%b ctrl=%h bub=%0d stall=%b want 0 000 1 0",
                         ex_valid_o, ex_ctrl_o, bubble_cnt_o, stall_o);
    end
    step();
    checks++;
    if ({ex_valid_o, ex_ctrl_o, ex_rd_o, ex_rs_data_o, bubble_cnt_o} !== {1'b1, C_ADD, 5'd4, 32'd9, 16'd1}) begin
      errors++; $display("FAIL lu_resume got valid=%b ctrl=%h rd=%0d rsd=%0d bub=%0d want 1 %h 4 9 1",
                         ex_valid_o, ex_ctrl_o, ex_rd_o, ex_rs_data_o, bubble_cnt_o, C_ADD);
    end
    // lw r2 ; add r4,r1,r2 (rt dependency, rt used since ALUSrc=0)
    drive(1'b1, C_LW, 5'd1, 5'd2, 5'd0, 32'd100, 32'd0, 16'h0004, 32'h208);
    step();
    drive(1'b1, C_ADD, 5'd1, 5'd2, 5'd4, 32'd9, 32'd3, 16'h0, 32'h20C);
    #1;
    checks++;
    if (stall_o !== 1'b1) begin errors++; $display("FAIL lu_rt_stall got %b want 1", stall_o); end
    step();
    step();
    // lw r2 ; addi r5,r1 with rt field = 2 (rt not a source)
    drive(1'b1, C_LW, 5'd1, 5'd2, 5'd0, 32'd100, 32'd0, 16'h0004, 32'h210);
    step();
    drive(1'b1, C_ADDI, 5'd1, 5'd2, 5'd0, 32'd9, 32'd3, 16'h0001, 32'h214);
    #1;
    checks++;
    if (stall_o !== 1'b0) begin errors++; $display("FAIL addi_no_stall got %b want 0", stall_o); end
    step();
    // lw r0 ; add r4,r0,r1 -> no stall
    drive(1'b1, C_LW, 5'd1, 5'd0, 5'd0, 32'd100, 32'd0, 16'h0004, 32'h218);
    step();
    drive(1'b1, C_ADD, 5'd0, 5'd1, 5'd4, 32'd0, 32'd3, 16'h0, 32'h21C);
    #1;
    checks++;
    if (stall_o !== 1'b0) begin errors++; $display("FAIL r0_no_stall got %b want 0", stall_o); end
    step();
    checks++;
    if ({ex_valid_o, ex_pc4_o, bubble_cnt_o} !== {1'b1, 32'h21C, 16'd2}) begin
      errors++; $display("FAIL r0_capture got valid=%b pc4=%h bub=%0d want 1 0000021c 2",
                         ex_valid_o, ex_pc4_o, bubble_cnt_o);
    end
  endtask

  task automatic test_extension();
    drive(1'b1, C_ADDI, 5'd1, 5'd5, 5'd0, 32'd0, 32'd0, 16'h8001, 32'h300);
    step();
    checks++;
    if (ex_imm_o !== 32'hFFFF8001) begin
      errors++; $display("FAIL sign_ext got %h want ffff8001", ex_imm_o);
    end
    drive(1'b1, C_ORI, 5'd1, 5'd5, 5'd0, 32'd0, 32'd0, 16'h8001, 32'h304);
    step();
    checks++;
    if (ex_imm_o !== 32'h00008001) begin
      errors++; $display("FAIL zero_ext got %h want 00008001", ex_imm_o);
    end
  endtask

  task automatic test_scrub();
    drive(1'b1, C_SW_RAW, 5'd1, 5'd2, 5'd0, 32'd0, 32'd0, 16'h0008, 32'h400);
    step();
    checks++;
    if (ex_ctrl_o !== C_SW_SCRB) begin
      errors++; $display("FAIL scrub got %h want %h", ex_ctrl_o, C_SW_SCRB);
    end
  endtask

  task automatic test_reset_mid_stall();
    drive(1'b1, C_LW, 5'd1, 5'd2, 5'd0, 32'd100, 32'd0, 16'h0004, 32'h500);
    step();
    drive(1'b1, C_ADD, 5'd2, 5'd1, 5'd4, 32'd9, 32'd3, 16'h0, 32'h504);
    #1;
    checks++;
    if (stall_o !== 1'b1) begin errors++; $display("FAIL pre_reset_stall got %b want 1", stall_o); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({stall_o, ex_valid_o, ex_ctrl_o, ex_rt_o, ex_imm_o, ex_pc4_o, bubble_cnt_o, flush_cnt_o} !== '0) begin
      errors++; $display("FAIL mid_reset got stall=%b valid=%b ctrl=%h rt=%0d imm=%h pc4=%h bub=%0d fl=%0d want all 0",
                         stall_o, ex_valid_o, ex_ctrl_o, ex_rt_o, ex_imm_o, ex_pc4_o, bubble_cnt_o, flush_cnt_o);
    end
    rst_n = 1'b1;
    drive(1'b0, '0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 16'd0, 32'd0);
    step();
  endtask

  task automatic test_flush_priority();
    drive(1'b1, C_LW, 5'd1, 5'd2, 5'd0, 32'd100, 32'd0, 16'h0004, 32'h600);
    step();
    drive(1'b1, C_ADD, 5'd2, 5'd1, 5'd4, 32'd9, 32'd3, 16'h0, 32'h604);
    flush_i = 1'b1;
    #1;
    checks++;
    if (stall_o !== 1'b0) begin errors++; $display("FAIL flush_stall got %b want 0", stall_o); end
    step();
    checks++;
    if ({ex_valid_o, ex_ctrl_o, flush_cnt_o, bubble_cnt_o} !== {1'b0, 11'h0, 16'd1, 16'd0}) begin
      errors++; $display("FAIL flush_bubble got valid=%b ctrl=%h fl=%0d bub=%0d want 0 000 1 0",
                         ex_valid_o, ex_ctrl_o, flush_cnt_o, bubble_cnt_o);
    end
    // Flush with nothing valid in ID does not count.
    id_valid_i = 1'b0;
    step();
    checks++;
    if (flush_cnt_o !== 16'd1) begin
      errors++; $display("FAIL flush_invalid got %0d want 1", flush_cnt_o);
    end
  endtask

  task automatic test_saturation();
    drive(1'b1, C_ADD, 5'd1, 5'd2, 5'd3, 32'd0, 32'd0, 16'h0, 32'h700);
    flush_i = 1'b1;
    for (int i = 0; i < 65533; i++) step();
    checks++;
    if (flush_cnt_o !== 16'hFFFE) begin
      errors++; $display("FAIL sat_near got %h want fffe", flush_cnt_o);
    end
    for (int i = 0; i < 70000 - 65533; i++) step();
    checks++;
    if ({flush_cnt_o, bubble_cnt_o} !== {16'hFFFF, 16'd0}) begin
      errors++; $display("FAIL sat_hold got fl=%h bub=%h want ffff 0000", flush_cnt_o, bubble_cnt_o);
    end
    flush_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_load_use();
    test_extension();
    test_scrub();
    test_reset_mid_stall();
    test_flush_priority();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
